seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 14 +
 rtl/seq_multiplier_if.sv | 15 +
 rtl/seq_multiplier_mag_conv.sv | 12 +
 rtl/seq_multiplier.sv | 138 +++++++++++++
 tb/tb_seq_multiplier.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared widths and FSM state type for the sequential shift-add multiplier.
package seq_mul_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/start/result bundle between a requester (master) and the multiplier (slave).
interface seq_multiplier_if;
    import seq_mul_pkg::*;

    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              S;
    logic [PROD_W-1:0] P;
    logic              F;
    logic              BUSY;

    modport master (output A, output B, output S, input P, input F, input BUSY);
    modport slave  (input A, input B, input S, output P, output F, output BUSY);

endinterface

// File: rtl/seq_multiplier_mag_conv.sv
// Conditional two's-complement negate; used for operand magnitudes and the signed product.
module mag_conv #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_multiplier.sv
// 16x16 sequential shift-add multiplier, one bit per cycle, fixed 16-cycle run.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands/product; default is unsigned.
module seq_multiplier
    import seq_mul_pkg::*;
(
    input  logic            C,
    input  logic            RST,
    seq_multiplier_if.slave bus
);

    state_t             state_q, state_d;
    logic               s_prev_q, s_prev_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PROD_W-1:0]  p_q, p_d;
    logic               f_q, f_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     sum_c;
    logic [PROD_W-1:0]  step_acc_c;
    logic [PROD_W-1:0]  prod_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;

    // One shift-add step: add into the upper half with a 17th carry bit, then shift right.
    assign sum_c      = {1'b0, acc_q[PROD_W-1 -: WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign step_acc_c = {sum_c, acc_q[WIDTH-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
    logic sign_q, sign_d;

    mag_conv #(.W(WIDTH)) u_mag_a (
        .val_i (bus.A),
        .neg_i (bus.A[WIDTH-1]),
        .res_o (a_mag_c)
    );

    mag_conv #(.W(WIDTH)) u_mag_b (
        .val_i (bus.B),
        .neg_i (bus.B[WIDTH-1]),
        .res_o (b_mag_c)
    );

    mag_conv #(.W(PROD_W)) u_mag_p (
        .val_i (step_acc_c),
        .neg_i (sign_q),
        .res_o (prod_c)
    );

    always_ff @(posedge C or posedge RST) begin
        if (RST) sign_q <= 1'b0;
        else     sign_q <= sign_d;
    end
`else
    assign a_mag_c = bus.A;
    assign b_mag_c = bus.B;
    assign prod_c  = step_acc_c;
`endif

    always_ff @(posedge C or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            s_prev_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            f_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_prev_q <= s_prev_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
            f_q      <= f_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_prev_d = bus.S;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        p_d      = p_q;
        f_d      = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
        sign_d   = sign_q;
`endif

        case (state_q)
            IDLE: begin
                // Only a rising edge of S starts; a held-high S is ignored.
                if (bus.S && !s_prev_q) begin
                    mcand_d  = a_mag_c;
                    mplier_d = b_mag_c;
                    acc_d    = '0;
                    count_d  = CNT_W'(WIDTH);
                    state_d  = RUN;
`ifdef SEQ_MUL_SIGNED_EN
                    sign_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`endif
                end
            end
            RUN: begin
                acc_d    = step_acc_c;
                mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    p_d     = prod_c;
                    f_d     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.P    = p_q;
    assign bus.F    = f_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: latency, product, start-edge filtering and reset abort.
module tb_seq_multiplier;
    import seq_mul_pkg::*;

    logic C = 1'b0;
    logic RST;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .C   (C),
        .RST (RST),
        .bus (bus)
    );

    always #5 C = ~C;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] sb_q[$];

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef SEQ_MUL_SIGNED_EN
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
`else
        return {16'h0000, a} * {16'h0000, b};
`endif
    endfunction

    // Start one operation and follow it for a fixed window, checking latency, product and F count.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int s_hold,
                          input int repulse_at, input bit rel_rst, input string name);
        int          first_f;
        int          pulses;
        int          n_end;
        logic [31:0] exp_p;
        exp_p   = model(a, b);
        first_f = 0;
        pulses  = 0;
        n_end   = (s_hold > 18) ? s_hold + 2 : 20;
        @(negedge C);
        bus.A = a;
        bus.B = b;
        bus.S = 1'b1;
        if (rel_rst) RST = 1'b0;
        sb_q.push_back(exp_p);
        for (int n = 1; n <= n_end; n++) begin
            @(negedge C);
            if (n == 1) begin
                bus.A = 16'($urandom);
                bus.B = 16'($urandom);
                tests_run++;
                if (bus.BUSY !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s busy_after_start: got %b want 1", name, bus.BUSY);
                end
            end
            if (bus.F === 1'b1) begin
                pulses++;
                if (first_f == 0) begin
                    first_f = n;
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL %s scoreboard_empty: got P=%h with no pending op", name, bus.P);
                    end else begin
                        logic [31:0] want;
                        want = sb_q.pop_front();
                        if (bus.P !== want) begin
                            tests_failed++;
                            $display("FAIL %s product: got %h want %h", name, bus.P, want);
                        end
                    end
                end
            end
            if (n == 18) begin
                tests_run++;
                if (bus.BUSY !== 1'b0 || bus.F !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s idle_after_done: got BUSY=%b F=%b want 0 0", name, bus.BUSY, bus.F);
                end
            end
            bus.S = (n < s_hold) || (n == repulse_at);
        end
        bus.S = 1'b0;
        tests_run++;
        if (first_f !== 17) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want 17 (0 = no F)", name, first_f);
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL %s f_pulses: got %0d want 1", name, pulses);
        end
        tests_run++;
        if (bus.P !== exp_p) begin
            tests_failed++;
            $display("FAIL %s p_hold: got %h want %h", name, bus.P, exp_p);
        end
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.S = 1'b0;
        repeat (2) @(negedge C);
        tests_run++;
        if (bus.P !== 32'h0 || bus.F !== 1'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got P=%h F=%b BUSY=%b want 0 0 0", bus.P, bus.F, bus.BUSY);
        end
        RST = 1'b0;
        @(negedge C);
    endtask

    task automatic test_products();
        logic [15:0] av[8] = '{16'd3, 16'hFFF9, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h1234, 16'h8001};
        logic [15:0] bv[8] = '{16'd5, 16'd6,    16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h00FF, 16'h7FFF};
        for (int i = 0; i < 8; i++) run_op(av[i], bv[i], 1, 0, 1'b0, $sformatf("prod%0d", i));
        for (int i = 0; i < 3; i++) run_op(16'($urandom), 16'($urandom), 1, 0, 1'b0, $sformatf("rand%0d", i));
    endtask

    task automatic test_back_to_back();
        run_op(16'h00FF, 16'h0101, 1, 0, 1'b0, "b2b_a");
        run_op(16'hF00F, 16'h0003, 1, 0, 1'b0, "b2b_b");
    endtask

    task automatic test_restart_ignored();
        run_op(16'h0123, 16'h0045, 1, 5, 1'b0, "repulse_run5");
        run_op(16'hABCD, 16'h0007, 40, 0, 1'b0, "s_held_high");
    endtask

    task automatic test_mid_reset();
        int pulses;
        pulses = 0;
        @(negedge C);
        bus.A = 16'h0F0F;
        bus.B = 16'h0033;
        bus.S = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge C);
            bus.S = 1'b0;
            if (bus.F === 1'b1) pulses++;
        end
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if (bus.P !== 32'h0 || bus.F !== 1'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got P=%h F=%b BUSY=%b want 0 0 0", bus.P, bus.F, bus.BUSY);
        end
        @(negedge C);
        RST = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge C);
            if (bus.F === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_abort: got F pulses=%0d BUSY=%b want 0 0", pulses, bus.BUSY);
        end
        run_op(16'h0011, 16'h0022, 1, 0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_start();
        @(negedge C);
        RST = 1'b1;
        #1;
        tests_run++;
        if (bus.P !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_clears_p: got %h want 0", bus.P);
        end
        run_op(16'h0009, 16'h000B, 1, 0, 1'b1, "start_at_release");
    endtask

    initial begin
        test_reset();
        test_products();
        test_back_to_back();
        test_restart_ignored();
        test_mid_reset();
        test_reset_start();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
